// File: rtl/float_max_scheduler.sv
// Streams a block of sign/exp/frac floats through one shared comparator and
// reports the block maximum, its index and a one-cycle done pulse.

module float_greater_than (
    input  logic       a_sign,
    input  logic [3:0] a_exp,
    input  logic [7:0] a_frac,
    input  logic       b_sign,
    input  logic [3:0] b_exp,
    input  logic [7:0] b_frac,
    output logic       gt
);
    logic [11:0] w_a_mag;
    logic [11:0] w_b_mag;

    assign w_a_mag = {a_exp, a_frac};
    assign w_b_mag = {b_exp, b_frac};

    // Sign-magnitude order: for negatives the smaller magnitude is the larger value.
    always_comb begin
        if (a_sign != b_sign) gt = ~a_sign;
        else if (a_sign)      gt = (w_a_mag < w_b_mag);
        else                  gt = (w_a_mag > w_b_mag);
    end
endmodule

module float_max_scheduler #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [3:0]       in_exp,
    input  logic [7:0]       in_frac,
    output logic             busy,
    output logic             done,
    output logic             max_sign,
    output logic [3:0]       max_exp,
    output logic [7:0]       max_frac,
    output logic [IDX_W-1:0] max_idx
);
    // IDLE: wait for start | FIRST: load element 0 | RUN: compare the rest | DONE: result pulse
    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_len;
    logic [IDX_W-1:0] r_cnt;
    logic             r_max_sign;
    logic [3:0]       r_max_exp;
    logic [7:0]       r_max_frac;
    logic [IDX_W-1:0] r_max_idx;
    logic             w_accept;
    logic             w_gt;
    logic             w_last;

    float_greater_than u_cmp (
        .a_sign (in_sign),
        .a_exp  (in_exp),
        .a_frac (in_frac),
        .b_sign (r_max_sign),
        .b_exp  (r_max_exp),
        .b_frac (r_max_frac),
        .gt     (w_gt)
    );

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == r_len);

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FIRST;
            end
            S_FIRST: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) w_next = (r_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_max_sign <= 1'b0;
            r_max_exp  <= 4'h0;
            r_max_frac <= 8'h00;
            r_max_idx  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len <= len;
                        r_cnt <= '0;
                    end
                end
                S_FIRST: begin
                    if (w_accept) begin
                        r_max_sign <= in_sign;
                        r_max_exp  <= in_exp;
                        r_max_frac <= in_frac;
                        r_max_idx  <= '0;
                        r_cnt      <= {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_gt) begin
                            r_max_sign <= in_sign;
                            r_max_exp  <= in_exp;
                            r_max_frac <= in_frac;
                            r_max_idx  <= r_cnt;
                        end
                        // Hold the count on the final accept so it never wraps.
                        if (!w_last) r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign max_sign = r_max_sign;
    assign max_exp  = r_max_exp;
    assign max_frac = r_max_frac;
    assign max_idx  = r_max_idx;
endmodule

// File: tb/tb_float_max_scheduler.sv
// Bench for float_max_scheduler: directed vector table, hand-written corner
// sequences and random blocks checked against an ordering-key reference model.

module tb_float_max_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [3:0] in_exp;
    logic [7:0] in_frac;
    logic       busy;
    logic       done;
    logic       max_sign;
    logic [3:0] max_exp;
    logic [7:0] max_frac;
    logic [3:0] max_idx;

    float_max_scheduler #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
        .busy(busy), .done(done),
        .max_sign(max_sign), .max_exp(max_exp), .max_frac(max_frac),
        .max_idx(max_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       len;
        logic [15:0][12:0] el;
        logic [12:0]       mx;
        logic [31:0]       idx;
    } vec_t;

    vec_t        vecs[7];
    int          errors = 0;
    int          checks = 0;
    logic [12:0] prev_max = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] mk(input int s, input int e, input int f);
        return {s[0], e[3:0], f[7:0]};
    endfunction

    // Total order on values: every negative below every positive, -0 just below +0.
    function automatic int key(input logic [12:0] f);
        int mag;
        mag = int'(f[11:0]);
        return f[12] ? (4095 - mag) : (4096 + mag);
    endfunction

    task automatic ref_max(input int blen, input logic [15:0][12:0] els,
                           output logic [12:0] mx, output int idx);
        int best;
        best = -1;
        mx   = '0;
        idx  = 0;
        for (int i = 0; i <= blen; i++) begin
            if (key(els[i]) > best) begin
                best = key(els[i]);
                mx   = els[i];
                idx  = i;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string tag, input int blen, input logic [15:0][12:0] els,
                             input int gap, input bit extra_start,
                             input logic [12:0] emx, input int eidx);
        int cyc, acc, lat;
        bit acc_now;
        logic [3:0] blen4;
        blen4    = blen[3:0];
        start    = 1'b1;
        len      = blen4;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        len   = ~blen4;
        check({tag, " first_busy"}, busy, 1);
        check({tag, " first_ready"}, in_ready, 1);
        check({tag, " held_prev"}, {max_sign, max_exp, max_frac}, prev_max);
        cyc = 0;
        acc = 0;
        lat = -1;
        while (lat < 0 && cyc < 300) begin
            in_valid = ((cyc % (gap + 1)) == 0) && (acc <= blen);
            if (acc < 16) {in_sign, in_exp, in_frac} = els[acc];
            start = extra_start && (cyc == 3);
            if (start) len = 4'd0;
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) acc++;
            cyc++;
            if (done) lat = cyc;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done expected done within 300 cycles", tag);
        end else begin
            check({tag, " latency"}, lat, blen * (gap + 1) + 1);
            check({tag, " accepts"}, acc, blen + 1);
            check({tag, " max"}, {max_sign, max_exp, max_frac}, emx);
            check({tag, " idx"}, max_idx, eidx);
            start = extra_start;
            tick();
            start = 1'b0;
            check({tag, " done_pulse"}, done, 0);
            check({tag, " idle_busy"}, busy, 0);
            check({tag, " max_stable"}, {max_sign, max_exp, max_frac}, emx);
        end
        prev_max = emx;
    endtask

    initial begin
        logic [15:0][12:0] els;
        logic [12:0]       mx;
        int                idx;
        int                dcnt;
        int                blen;

        for (int v = 0; v < 7; v++) vecs[v] = '0;
        vecs[0].len = 2; vecs[0].el[0] = mk(0,3,87); vecs[0].el[1] = mk(0,3,97);
        vecs[0].el[2] = mk(1,4,48); vecs[0].mx = mk(0,3,97); vecs[0].idx = 1;
        vecs[1].len = 1; vecs[1].el[0] = mk(1,6,57); vecs[1].el[1] = mk(1,6,45);
        vecs[1].mx = mk(1,6,45); vecs[1].idx = 1;
        vecs[2].len = 2; vecs[2].el[0] = mk(0,5,12); vecs[2].el[1] = mk(0,5,32);
        vecs[2].el[2] = mk(0,5,32); vecs[2].mx = mk(0,5,32); vecs[2].idx = 1;
        vecs[3].len = 0; vecs[3].el[0] = mk(1,4,48); vecs[3].mx = mk(1,4,48); vecs[3].idx = 0;
        vecs[4].len = 15;
        for (int i = 0; i < 16; i++) vecs[4].el[i] = mk(0, i, 7);
        vecs[4].mx = mk(0,15,7); vecs[4].idx = 15;
        vecs[5].len = 3; vecs[5].el[0] = mk(1,0,0); vecs[5].el[1] = mk(0,0,0);
        vecs[5].el[2] = mk(1,2,5); vecs[5].el[3] = mk(0,0,0);
        vecs[5].mx = mk(0,0,0); vecs[5].idx = 1;
        vecs[6].len = 3; vecs[6].el[0] = mk(0,2,10); vecs[6].el[1] = mk(0,9,1);
        vecs[6].el[2] = mk(1,9,1); vecs[6].el[3] = mk(0,9,1);
        vecs[6].mx = mk(0,9,1); vecs[6].idx = 1;

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_frac = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst in_ready", in_ready, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst max", {max_sign, max_exp, max_frac}, 0);
        check("rst idx", max_idx, 0);

        for (int v = 0; v < 7; v++)
            run_block($sformatf("vec%0d", v), int'(vecs[v].len), vecs[v].el, 0, 1'b0,
                      vecs[v].mx, int'(vecs[v].idx));

        // Gapped stream with a stray start mid-block and during DONE.
        run_block("gapped", 3, vecs[6].el, 2, 1'b1, vecs[6].mx, int'(vecs[6].idx));

        // Reset after two accepts discards the partial block.
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0; in_valid = 1'b1;
        {in_sign, in_exp, in_frac} = mk(0,7,200);
        tick();
        {in_sign, in_exp, in_frac} = mk(0,8,1);
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst max", {max_sign, max_exp, max_frac}, 0);
        check("midrst idx", max_idx, 0);
        check("midrst busy", busy, 0);
        check("midrst ready", in_ready, 0);
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) dcnt++;
            tick();
        end
        check("midrst no_done", dcnt, 0);
        prev_max = '0;
        run_block("after_rst", 2, vecs[0].el, 0, 1'b0, vecs[0].mx, int'(vecs[0].idx));

        for (int r = 0; r < 25; r++) begin
            blen = $urandom_range(0, 15);
            els  = '0;
            for (int i = 0; i < 16; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) els[i] = els[$urandom_range(0, i - 1)];
                else                                    els[i] = 13'($urandom);
            end
            ref_max(blen, els, mx, idx);
            run_block($sformatf("rand%0d", r), blen, els, $urandom_range(0, 2), 1'b0, mx, idx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
